// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler: round-robin arbiter that shares one register/ALU
// datapath between two requesters, sequencing each granted operation as
// load A, load B, execute, respond.

module alu_req_scheduler #(
  parameter int WIDTH       = 16,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [1:0]       req,
  input  logic [2:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [2:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       ack,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [2:0]       cs_out,
  output logic [WIDTH-1:0] dp_din,
  output logic             dp_we,
  output logic             dp_w1,
  output logic [2:0]       dp_ms,
  input  logic [WIDTH-1:0] dp_alu
);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    LOAD_A = 3'b001,
    LOAD_B = 3'b010,
    EXEC   = 3'b011,
    RESP   = 3'b100
  } state_t;

  // Counter value on the final EXEC cycle, when the ALU output is sampled.
  localparam logic [2:0] EXEC_LAST = 3'(EXEC_CYCLES - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic             r_ptr;
  logic             r_grant;
  logic [2:0]       r_op;
  logic [2:0]       r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             w_grant;
  logic             w_execDone;

  assign w_execDone = (r_cnt == EXEC_LAST);

  // Pick the winner: a lone requester wins outright, a tie goes to the pointer.
  always_comb begin
    w_grant = r_ptr;
    case (req)
      2'b01:   w_grant = 1'b0;
      2'b10:   w_grant = 1'b1;
      default: w_grant = r_ptr;
    endcase
  end

  // State register; reset abandons any in-flight operation without an ack.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode; unused encodings fall back to IDLE.
  always_comb begin
    w_nextState = IDLE;
    case (r_state)
      IDLE:    w_nextState = (|req) ? LOAD_A : IDLE;
      LOAD_A:  w_nextState = LOAD_B;
      LOAD_B:  w_nextState = EXEC;
      EXEC:    w_nextState = w_execDone ? RESP : EXEC;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Operand latch at grant, exec counter, result capture and pointer update.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_ptr    <= 1'b0;
      r_grant  <= 1'b0;
      r_op     <= 3'b000;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= 3'b000;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_grant <= w_grant;
            r_op    <= w_grant ? op1 : op0;
            r_a     <= w_grant ? a1 : a0;
            r_b     <= w_grant ? b1 : b0;
          end
        end
        LOAD_B: begin
          r_cnt <= 3'b000;
        end
        EXEC: begin
          r_cnt <= r_cnt + 3'b001;
          if (w_execDone) begin
            r_result <= dp_alu;
          end
        end
        RESP: begin
          r_ptr <= ~r_grant;
        end
        default: begin
          r_cnt <= 3'b000;
        end
      endcase
    end
  end

  // Datapath controls and ack decoded purely from state and latched registers.
  always_comb begin
    ack    = 2'b00;
    dp_we  = 1'b0;
    dp_w1  = 1'b0;
    dp_ms  = 3'b000;
    dp_din = '0;
    case (r_state)
      LOAD_A: begin
        dp_we  = 1'b1;
        dp_din = r_a;
      end
      LOAD_B: begin
        dp_we  = 1'b1;
        dp_w1  = 1'b1;
        dp_din = r_b;
      end
      EXEC: begin
        dp_ms = r_op;
      end
      RESP: begin
        ack = r_grant ? 2'b10 : 2'b01;
      end
      default: begin
        ack = 2'b00;
      end
    endcase
  end

  assign busy   = (r_state != IDLE);
  assign cs_out = r_state;
  assign result = r_result;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// tb_alu_req_scheduler: directed bench for alu_req_scheduler with a small
// register/ALU datapath model (001 = A+B, 010 = A-B) behind each instance.

module tb_alu_req_scheduler;

  logic        clk = 1'b0;
  logic        clear_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  req3 = 2'b00;
  logic [2:0]  op0 = 3'b000;
  logic [15:0] a0 = 16'h0000;
  logic [15:0] b0 = 16'h0000;
  logic [2:0]  op1 = 3'b000;
  logic [15:0] a1 = 16'h0000;
  logic [15:0] b1 = 16'h0000;

  logic [1:0]  ack, ack3;
  logic [15:0] result, result3;
  logic        busy, busy3;
  logic [2:0]  csOut, csOut3;
  logic [15:0] dpDin, dpDin3;
  logic        dpWe, dpWe3;
  logic        dpW1, dpW13;
  logic [2:0]  dpMs, dpMs3;
  logic [15:0] dpAlu, dpAlu3;

  logic [15:0] dpRegA = 16'h0000, dpRegB = 16'h0000;
  logic [15:0] dpRegA3 = 16'h0000, dpRegB3 = 16'h0000;

  int nAsserts = 0;
  int nFails = 0;

  alu_req_scheduler #(.WIDTH(16), .EXEC_CYCLES(1)) u_dut (
    .clk(clk), .clear_n(clear_n), .req(req),
    .op0(op0), .a0(a0), .b0(b0), .op1(op1), .a1(a1), .b1(b1),
    .ack(ack), .result(result), .busy(busy), .cs_out(csOut),
    .dp_din(dpDin), .dp_we(dpWe), .dp_w1(dpW1), .dp_ms(dpMs), .dp_alu(dpAlu)
  );

  alu_req_scheduler #(.WIDTH(16), .EXEC_CYCLES(3)) u_dut3 (
    .clk(clk), .clear_n(clear_n), .req(req3),
    .op0(op0), .a0(a0), .b0(b0), .op1(op1), .a1(a1), .b1(b1),
    .ack(ack3), .result(result3), .busy(busy3), .cs_out(csOut3),
    .dp_din(dpDin3), .dp_we(dpWe3), .dp_w1(dpW13), .dp_ms(dpMs3), .dp_alu(dpAlu3)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Datapath register model for the default instance.
  always @(posedge clk) begin
    if (dpWe) begin
      if (dpW1) dpRegB <= dpDin;
      else      dpRegA <= dpDin;
    end
  end

  // Datapath ALU model for the default instance.
  always_comb begin
    dpAlu = 16'h0000;
    case (dpMs)
      3'b001:  dpAlu = dpRegA + dpRegB;
      3'b010:  dpAlu = dpRegA - dpRegB;
      default: dpAlu = 16'h0000;
    endcase
  end

  // Datapath register model for the three-cycle-exec instance.
  always @(posedge clk) begin
    if (dpWe3) begin
      if (dpW13) dpRegB3 <= dpDin3;
      else       dpRegA3 <= dpDin3;
    end
  end

  // Datapath ALU model for the three-cycle-exec instance.
  always_comb begin
    dpAlu3 = 16'h0000;
    case (dpMs3)
      3'b001:  dpAlu3 = dpRegA3 + dpRegB3;
      3'b010:  dpAlu3 = dpRegA3 - dpRegB3;
      default: dpAlu3 = 16'h0000;
    endcase
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [2:0] o0,
                               input logic [15:0] x0, input logic [15:0] y0,
                               input logic [2:0] o1, input logic [15:0] x1,
                               input logic [15:0] y1);
    req = r;
    op0 = o0; a0 = x0; b0 = y0;
    op1 = o1; a1 = x1; b1 = y1;
  endtask

  task automatic stepCycle();
    @(negedge clk);
  endtask

  task automatic doReset();
    clear_n = 1'b0;
    #2;
    clear_n = 1'b1;
    @(negedge clk);
  endtask

  // Advance until ack appears (bounded), then check ack and result.
  task automatic waitAck(input string tag, input logic [1:0] expAck,
                         input logic [15:0] expRes);
    int n = 0;
    while (ack == 2'b00 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_ack"}, 32'(ack), 32'(expAck));
    checkOutput({tag, "_result"}, 32'(result), 32'(expRes));
  endtask

  initial begin
    // Reset state while clear_n is held low.
    @(negedge clk);
    checkOutput("rst_cs", 32'(csOut), 32'h0);
    checkOutput("rst_ack", 32'(ack), 32'h0);
    checkOutput("rst_result", 32'(result), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_dpwe", 32'(dpWe), 32'h0);
    checkOutput("rst_dpdin", 32'(dpDin), 32'h0);
    clear_n = 1'b1;
    @(negedge clk);

    // Single request from requester 0: 5 + 3.
    applyStimulus(2'b01, 3'b001, 16'h0005, 16'h0003, 3'b000, 16'h0000, 16'h0000);
    checkOutput("single_c0_cs", 32'(csOut), 32'h0);
    stepCycle();
    checkOutput("single_c1_cs", 32'(csOut), 32'h1);
    checkOutput("single_c1_we", 32'(dpWe), 32'h1);
    checkOutput("single_c1_w1", 32'(dpW1), 32'h0);
    checkOutput("single_c1_din", 32'(dpDin), 32'h0005);
    checkOutput("single_c1_busy", 32'(busy), 32'h1);
    stepCycle();
    checkOutput("single_c2_cs", 32'(csOut), 32'h2);
    checkOutput("single_c2_we", 32'(dpWe), 32'h1);
    checkOutput("single_c2_w1", 32'(dpW1), 32'h1);
    checkOutput("single_c2_din", 32'(dpDin), 32'h0003);
    stepCycle();
    checkOutput("single_c3_cs", 32'(csOut), 32'h3);
    checkOutput("single_c3_we", 32'(dpWe), 32'h0);
    checkOutput("single_c3_ms", 32'(dpMs), 32'h1);
    checkOutput("single_c3_ack", 32'(ack), 32'h0);
    stepCycle();
    checkOutput("single_c4_cs", 32'(csOut), 32'h4);
    checkOutput("single_c4_ack", 32'(ack), 32'h1);
    checkOutput("single_c4_result", 32'(result), 32'h0008);
    checkOutput("single_c4_ms", 32'(dpMs), 32'h0);
    req = 2'b00;
    stepCycle();
    checkOutput("single_c5_cs", 32'(csOut), 32'h0);
    checkOutput("single_c5_ack", 32'(ack), 32'h0);
    checkOutput("single_c5_busy", 32'(busy), 32'h0);
    checkOutput("single_c5_result_held", 32'(result), 32'h0008);

    // Simultaneous continuous requests after reset: grants alternate 0,1,0,1.
    doReset();
    applyStimulus(2'b11, 3'b001, 16'h0010, 16'h0001, 3'b010, 16'h0010, 16'h0001);
    waitAck("rr_op1", 2'b01, 16'h0011);
    stepCycle();
    waitAck("rr_op2", 2'b10, 16'h000F);
    stepCycle();
    waitAck("rr_op3", 2'b01, 16'h0011);
    stepCycle();
    waitAck("rr_op4", 2'b10, 16'h000F);
    req = 2'b00;
    stepCycle();
    checkOutput("rr_idle_cs", 32'(csOut), 32'h0);

    // Subtract wrap on requester 1: 0 - 1.
    applyStimulus(2'b10, 3'b000, 16'h0000, 16'h0000, 3'b010, 16'h0000, 16'h0001);
    waitAck("wrap", 2'b10, 16'hFFFF);
    req = 2'b00;
    stepCycle();

    // Reset during EXEC, then the held request is served again.
    applyStimulus(2'b01, 3'b001, 16'h0005, 16'h0003, 3'b000, 16'h0000, 16'h0000);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("midrst_exec_cs", 32'(csOut), 32'h3);
    #1;
    clear_n = 1'b0;
    #1;
    checkOutput("midrst_cs", 32'(csOut), 32'h0);
    checkOutput("midrst_ack", 32'(ack), 32'h0);
    checkOutput("midrst_result", 32'(result), 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    checkOutput("midrst_we", 32'(dpWe), 32'h0);
    checkOutput("midrst_ms", 32'(dpMs), 32'h0);
    checkOutput("midrst_din", 32'(dpDin), 32'h0);
    #1;
    clear_n = 1'b1;
    stepCycle();
    checkOutput("midrst_reserve_cs", 32'(csOut), 32'h1);
    checkOutput("midrst_reserve_din", 32'(dpDin), 32'h0005);
    waitAck("midrst_reserve", 2'b01, 16'h0008);
    req = 2'b00;
    stepCycle();

    // Operand change after grant has no effect.
    applyStimulus(2'b01, 3'b001, 16'h0005, 16'h0003, 3'b000, 16'h0000, 16'h0000);
    stepCycle();
    stepCycle();
    checkOutput("opchg_lb_cs", 32'(csOut), 32'h2);
    a0 = 16'h00FF;
    waitAck("opchg", 2'b01, 16'h0008);
    req = 2'b00;
    stepCycle();

    // Three-cycle exec instance: 7 + 2, ack on cycle 6.
    applyStimulus(2'b00, 3'b001, 16'h0007, 16'h0002, 3'b000, 16'h0000, 16'h0000);
    req3 = 2'b01;
    stepCycle();
    checkOutput("exec3_c1_cs", 32'(csOut3), 32'h1);
    stepCycle();
    checkOutput("exec3_c2_cs", 32'(csOut3), 32'h2);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput($sformatf("exec3_c%0d_cs", i + 3), 32'(csOut3), 32'h3);
      checkOutput($sformatf("exec3_c%0d_ms", i + 3), 32'(dpMs3), 32'h1);
      checkOutput($sformatf("exec3_c%0d_ack", i + 3), 32'(ack3), 32'h0);
    end
    stepCycle();
    checkOutput("exec3_c6_cs", 32'(csOut3), 32'h4);
    checkOutput("exec3_c6_ack", 32'(ack3), 32'h1);
    checkOutput("exec3_c6_result", 32'(result3), 32'h0009);
    req3 = 2'b00;
    stepCycle();
    checkOutput("exec3_c7_ack", 32'(ack3), 32'h0);
    checkOutput("main_idle_during_exec3", 32'(csOut), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
- Shares the single register/ALU datapath between two independent requesters.
- Round-robin arbitration; the granted operation is sequenced as load A, load B, execute, respond.
- Drives the datapath's write-enable, write-select, mode-select and data-in lines, and captures the ALU output for the winner.
- Sits between the requesting engines and the datapath; replaces the single-user next/Done FSM path when more than one requester exists.

Parameters:
- WIDTH, 16: operand/result width.
- EXEC_CYCLES, 1: cycles mode-select is held before the ALU output is sampled (1..7).

Ports:
- clk  in  1  system clock, rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- req  in  2  request, bit i = requester i; level, held until ack.
- op0  in  3  requester 0 ALU mode.
- a0  in  WIDTH  requester 0 operand A.
- b0  in  WIDTH  requester 0 operand B.
- op1  in  3  requester 1 ALU mode.
- a1  in  WIDTH  requester 1 operand A.
- b1  in  WIDTH  requester 1 operand B.
- ack  out  2  one-cycle completion pulse per requester.
- result  out  WIDTH  captured ALU result; valid while ack is high, held until the next capture.
- busy  out  1  high in any state except IDLE.
- cs_out  out  3  current state encoding.
- dp_din  out  WIDTH  datapath data-in.
- dp_we  out  1  datapath register write enable.
- dp_w1  out  1  datapath write select; 0 = register A, 1 = register B.
- dp_ms  out  3  datapath ALU mode select.
- dp_alu  in  WIDTH  datapath ALU output; combinational from registers A/B and dp_ms.

Behaviour:
- States and cs_out encoding: IDLE = 000, LOAD_A = 001, LOAD_B = 010, EXEC = 011, RESP = 100. Encodings 101–111 go to IDLE on the next edge.
- Reset (clear_n low, async, any state including mid-operation):
  - State = IDLE, priority pointer = 0.
  - ack = 00, result = 0, busy = 0, dp_we = 0, dp_w1 = 0, dp_ms = 000, dp_din = 0.
  - Any in-flight operation is discarded; no ack is issued for it.
- IDLE: all datapath outputs 0. If any req bit is high at the edge:
  - Grant g = the sole requester, or the pointer value if both are requesting.
  - Latch op_g, a_g, b_g into internal registers; go to LOAD_A.
- LOAD_A: dp_we = 1, dp_w1 = 0, dp_din = latched A, dp_ms = 000. Next state LOAD_B.
- LOAD_B: dp_we = 1, dp_w1 = 1, dp_din = latched B, dp_ms = 000. Next state EXEC.
- EXEC:
  - dp_we = 0, dp_ms = latched op, dp_din = 0.
  - Internal counter runs EXEC_CYCLES cycles.
  - On the last cycle's edge, result <= dp_alu; go to RESP.
- RESP:
  - ack[g] = 1 for exactly one cycle; result valid; dp_ms = 000.
  - Pointer <= ~g. Next state IDLE.
- Latency: req sampled in IDLE at cycle 0 → ack at cycle 3 + EXEC_CYCLES (cycle 4 at default). Back-to-back grant throughput is one operation per 4 + EXEC_CYCLES cycles.
- Operands are latched at grant. Requester input changes after grant have no effect on the operation.
- Dropping req after grant does not abort the operation; ack still pulses.
- Requester protocol: deassert req in the cycle after ack. A req still high when the scheduler is back in IDLE is treated as a new request.
- Non-granted requester: its req stays pending and is served next, since the pointer now favours it.
- Fairness: under continuous requests from both, grants alternate 0, 1, 0, 1, …
- busy = 1 in LOAD_A, LOAD_B, EXEC and RESP.
- ack bits are mutually exclusive. ack is never high outside RESP.
- All outputs are registered or decoded from state only. No combinational path exists from req to datapath outputs.

Test Plan:
- Bench datapath model: ms 001 = A+B, 010 = A−B.
- Single request: req = 01, op0 = 001, a0 = 0x0005, b0 = 0x0003 →
  - cycle 1: dp_we = 1, dp_w1 = 0, dp_din = 0x0005.
  - cycle 2: dp_we = 1, dp_w1 = 1, dp_din = 0x0003.
  - cycle 3: dp_ms = 001.
  - cycle 4: ack = 01, result = 0x0008, cs_out sequence 000, 001, 010, 011, 100, 000.
- Simultaneous requests after reset: req = 11, req0 = (001, 0x0010, 0x0001), req1 = (010, 0x0010, 0x0001) →
  - requester 0 served first: ack = 01, result = 0x0011.
  - then requester 1: ack = 10, result = 0x000F.
  - grant order continues alternating 0, 1, 0, 1 over 4 operations.
- Subtract wrap: req1, op1 = 010, a1 = 0x0000, b1 = 0x0001 → result = 0xFFFF.
- Reset mid-op: assert clear_n = 0 during EXEC →
  - immediately cs_out = 000, all outputs 0, no ack.
  - after release, a held req is re-served from LOAD_A.
- Operand change after grant: change a0 to 0x00FF in LOAD_B → result still uses 0x0005.
- EXEC_CYCLES = 3 build: ack at cycle 6; dp_ms held for 3 cycles; result captured from dp_alu on the third EXEC cycle.
